wb_byte_master: RTL and testbench

- Host-debug bridge that turns a byte stream into Wishbone master cycles.
- Byte stream comes from an external UART PHY through valid/ready handshakes.
- Sits directly upstream of the SoC interconnect and drives one external master slot (`ext_masters`).
- Lets a host read and write any slave in the address map (ROM0, BRAM0, external slaves) independently of the CPU.

---
 rtl/wb_byte_master_if.sv | 45 ++++
 rtl/wb_byte_master.sv | 185 ++++++++++++++++++
 tb/tb_wb_byte_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_byte_master_if.sv
// rtl/wb_byte_master_if.sv - byte-stream and Wishbone signal bundle for wb_byte_master
//
// Purpose: groups the host byte streams (rx/tx valid-ready), the Wishbone
// master signals and the busy flag so the bridge takes a single bundle port.
// Ports (signals):
//   rx_valid/rx_ready/rx_data  incoming command bytes from the UART PHY
//   tx_valid/tx_ready/tx_data  outgoing response bytes to the UART PHY
//   wb_cyc/wb_stb/wb_we/wb_tag/wb_sel/wb_adr/wb_mosi  Wishbone master outputs
//   wb_miso/wb_ack/wb_err      Wishbone slave returns
//   busy                       bridge is mid-command
// Modports: master (the bridge), slave (PHY + interconnect side).
interface wb_byte_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 1
);
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            rx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [TAG_WIDTH-1:0]  wb_tag;
  logic [3:0]            wb_sel;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [31:0]           wb_mosi;
  logic [31:0]           wb_miso;
  logic                  wb_ack;
  logic                  wb_err;
  logic                  busy;

  modport master (
    input  rx_valid, rx_data, tx_ready, wb_miso, wb_ack, wb_err,
    output rx_ready, tx_valid, tx_data, wb_cyc, wb_stb, wb_we, wb_tag,
           wb_sel, wb_adr, wb_mosi, busy
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, wb_miso, wb_ack, wb_err,
    input  rx_ready, tx_valid, tx_data, wb_cyc, wb_stb, wb_we, wb_tag,
           wb_sel, wb_adr, wb_mosi, busy
  );
endinterface

// File: rtl/wb_byte_master.sv
// rtl/wb_byte_master.sv - host-debug bridge turning a byte stream into Wishbone cycles
//
// Purpose: receives cmd(1) + addr(4, LE) [+ wdata(4, LE)] bytes, runs one
// classic Wishbone cycle, and returns status(1) [+ rdata(4, LE) for reads].
// Commands: 0x01 write, 0x02 read, anything else -> status 0xFF, no bus cycle.
// Status: 0x00 ack, 0x01 err (wins over ack), 0x02 timeout, 0xFF bad command.
// Ports:
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   bus        wb_byte_master_if.master: rx/tx byte streams, Wishbone master, busy
module wb_byte_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  wb_byte_master_if.master       bus
);

  localparam int              CW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [1:0]            r_idx;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic                  r_rd;
  logic                  r_stat_sent;
  logic [7:0]            r_status;
  logic [31:0]           r_adr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_rx_ready;
  logic                  w_tx_valid;
  logic                  w_bus_act;
  logic                  w_rx_fire;
  logic                  w_tx_fire;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_rx_ready = 1'b0;
    w_tx_valid = 1'b0;
    w_bus_act  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
            w_next = S_ADDR;
          end else begin
            w_next = S_RESP;
          end
        end
      end
      S_ADDR: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid && r_idx == 2'd3) begin
          w_next = r_we ? S_WDATA : S_BUS;
        end
      end
      S_WDATA: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid && r_idx == 2'd3) begin
          w_next = S_BUS;
        end
      end
      S_BUS: begin
        w_bus_act = 1'b1;
        if (bus.wb_ack || bus.wb_err || r_cnt == C_LAST) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_tx_valid = 1'b1;
        // Writes and bad commands end after the status byte; reads after 4 data bytes.
        if (bus.tx_ready && (r_stat_sent ? (r_idx == 2'd3) : !r_rd)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rx_fire = w_rx_ready & bus.rx_valid;
  assign w_tx_fire = w_tx_valid & bus.tx_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_rd        <= 1'b0;
      r_stat_sent <= 1'b0;
      r_status    <= '0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      // Byte index restarts on every state change; the status byte does not advance it.
      if (w_next != r_state) begin
        r_idx <= '0;
      end else if (w_rx_fire || (w_tx_fire && r_stat_sent)) begin
        r_idx <= r_idx + 2'd1;
      end

      if (r_state != S_BUS) begin
        r_cnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.rx_valid) begin
            r_we        <= (bus.rx_data == 8'h01);
            r_rd        <= (bus.rx_data == 8'h02);
            r_status    <= (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) ? 8'h00 : 8'hFF;
            r_stat_sent <= 1'b0;
            r_rdata     <= '0;
          end
        end
        S_ADDR: begin
          if (bus.rx_valid) begin
            r_adr[{r_idx, 3'b000} +: 8] <= bus.rx_data;
          end
        end
        S_WDATA: begin
          if (bus.rx_valid) begin
            r_wdata[{r_idx, 3'b000} +: 8] <= bus.rx_data;
          end
        end
        S_BUS: begin
          if (bus.wb_ack || bus.wb_err) begin
            r_status <= bus.wb_err ? 8'h01 : 8'h00;
            r_rdata  <= (r_rd && !bus.wb_err) ? bus.wb_miso : '0;
          end else if (r_cnt == C_LAST) begin
            r_status <= 8'h02;
            r_rdata  <= '0;
          end else begin
            // Only reached below C_LAST, so the counter can never wrap.
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.tx_ready && !r_stat_sent) begin
            r_stat_sent <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready = w_rx_ready;
  assign bus.tx_valid = w_tx_valid;
  assign bus.tx_data  = r_stat_sent ? r_rdata[{r_idx, 3'b000} +: 8] : r_status;
  assign bus.wb_cyc   = w_bus_act;
  assign bus.wb_stb   = w_bus_act;
  assign bus.wb_we    = w_bus_act & r_we;
  assign bus.wb_tag   = '0;
  assign bus.wb_sel   = {4{w_bus_act}};
  assign bus.wb_adr   = r_adr[ADDR_WIDTH-1:0];
  assign bus.wb_mosi  = r_wdata;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_wb_byte_master.sv
// tb/tb_wb_byte_master.sv - self-checking bench for wb_byte_master
module tb_wb_byte_master;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_byte_master_if #(.ADDR_WIDTH(32), .TAG_WIDTH(1)) bus ();

  wb_byte_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TAG_WIDTH(1),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    int gap;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 no response (timeout)
  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                         input int kind, input int lat, input logic [31:0] miso, input int stall0);
    logic [7:0]  exp_q[$];
    logic [7:0]  status;
    logic [31:0] d;
    logic [31:0] m0;
    logic [7:0]  held_data;
    bit          valid;
    bit          held;
    int          cycles;
    int          stable;
    int          unstable;
    int          got;
    int          guard;
    int          stall;

    valid = (cmd == 8'h01 || cmd == 8'h02);
    if (valid) begin
      status = (kind == 0) ? 8'h00 : (kind == 3) ? 8'h02 : 8'h01;
      exp_q.push_back(status);
      if (cmd == 8'h02) begin
        d = (kind == 0) ? miso : 32'h0;
        for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
      end
    end else begin
      exp_q.push_back(8'hFF);
    end

    send_byte(cmd);
    if (valid) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (cmd == 8'h01) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
    end

    if (valid) begin
      check("cyc_stb_start", {bus.wb_cyc, bus.wb_stb}, 2'b11);
      check("busy_in_bus", bus.busy, 1);
      check("rx_ready_in_bus", bus.rx_ready, 0);
      check("we", bus.wb_we, (cmd == 8'h01));
      check("sel", bus.wb_sel, 4'hF);
      check("adr", bus.wb_adr, addr);
      if (cmd == 8'h01) check("mosi", bus.wb_mosi, wdata);
      m0 = bus.wb_mosi;
      cycles = 0;
      stable = 1;
      @(negedge clk);
      while (bus.wb_cyc && cycles < 100) begin
        if (bus.wb_adr !== addr || bus.wb_mosi !== m0 || bus.wb_stb !== 1'b1 || bus.wb_sel !== 4'hF)
          stable = 0;
        bus.wb_miso = $urandom;
        if (kind != 3 && cycles == lat) begin
          bus.wb_ack  = (kind != 1);
          bus.wb_err  = (kind != 0);
          bus.wb_miso = miso;
        end
        @(posedge clk);
        #1;
        bus.wb_ack = 1'b0;
        bus.wb_err = 1'b0;
        cycles++;
        @(negedge clk);
      end
      check("cyc_len", cycles, (kind == 3) ? TO : lat + 1);
      check("bus_hold_stable", stable, 1);
    end else begin
      check("no_cyc_bad_cmd", bus.wb_cyc, 0);
    end

    got = 0;
    guard = 0;
    stall = stall0;
    held = 0;
    held_data = 8'h0;
    unstable = 0;
    while (got < exp_q.size() && guard < 500) begin
      @(negedge clk);
      guard++;
      if (bus.wb_cyc) unstable++;
      if (stall > 0) begin
        bus.tx_ready = 1'b0;
        stall--;
      end else begin
        bus.tx_ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.tx_valid) begin
        if (held && bus.tx_data !== held_data) unstable++;
        held = 1;
        held_data = bus.tx_data;
        if (bus.tx_ready) begin
          check($sformatf("tx_byte%0d", got), bus.tx_data, exp_q[got]);
          got++;
          held = 0;
          @(posedge clk);
          #1;
          if (got == exp_q.size()) begin
            check("busy_after", bus.busy, 0);
            check("tx_valid_after", bus.tx_valid, 0);
            check("rx_ready_after", bus.rx_ready, 1);
          end
        end
      end
    end
    if (got < exp_q.size()) check("tx_count", got, exp_q.size());
    check("tx_stable", unstable, 0);
    bus.tx_ready = 1'b0;
  endtask

  task automatic reset_in_bus();
    int txv;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h55);
    check("rst_pre_cyc", bus.wb_cyc, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_cyc_stb", {bus.wb_cyc, bus.wb_stb}, 2'b00);
    check("rst_async_busy", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rx_ready", bus.rx_ready, 1);
    txv = 0;
    bus.tx_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.tx_valid || bus.wb_cyc) txv++;
    end
    bus.tx_ready = 1'b0;
    check("rst_no_tx", txv, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0]  cmd;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] m;
    int          kind;
    int          lat;
    int          r;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    bus.wb_miso  = 32'h0;
    bus.wb_ack   = 1'b0;
    bus.wb_err   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_rx_ready", bus.rx_ready, 1);
    check("reset_tx_valid", bus.tx_valid, 0);
    check("reset_cyc_stb", {bus.wb_cyc, bus.wb_stb}, 2'b00);
    check("reset_we_sel", {bus.wb_we, bus.wb_sel}, 5'b0);
    check("reset_adr_mosi", {bus.wb_adr, bus.wb_mosi}, 64'h0);
    check("reset_busy", bus.busy, 0);
    check("reset_tag", bus.wb_tag, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_rx_ready", bus.rx_ready, 1);

    run_txn(8'h01, 32'h0000_4000, 32'hDEAD_BEEF, 0, 3, 32'h0, 0);
    run_txn(8'h02, 32'h0000_4004, 32'h0, 0, 1, 32'h1234_5678, 0);
    run_txn(8'h02, 32'h0000_4008, 32'h0, 1, 0, 32'hCAFE_F00D, 0);
    run_txn(8'h02, 32'h0000_400C, 32'h0, 2, 2, 32'hCAFE_F00D, 0);
    run_txn(8'h02, 32'hF000_0000, 32'h0, 3, 0, 32'h0, 0);
    run_txn(8'h7A, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    run_txn(8'h02, 32'h0000_0010, 32'h0, 0, 0, 32'hA5C3_0F81, 10);
    run_txn(8'h02, 32'h0000_0014, 32'h0, 0, TO - 1, 32'h7E57_0001, 0);
    run_txn(8'h01, 32'h0000_0018, 32'h0102_0304, 1, 4, 32'h0, 10);
    run_txn(8'h01, 32'h0000_001C, 32'h0506_0708, 3, 0, 32'h0, 0);

    reset_in_bus();
    run_txn(8'h02, 32'h0000_4004, 32'h0, 0, 2, 32'h8765_4321, 0);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 19);
      if (r < 9)       cmd = 8'h01;
      else if (r < 18) cmd = 8'h02;
      else begin
        cmd = 8'($urandom);
        if (cmd == 8'h01 || cmd == 8'h02) cmd = 8'h00;
      end
      a = $urandom;
      w = $urandom;
      m = $urandom;
      r = $urandom_range(0, 9);
      kind = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      lat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 4));
      run_txn(cmd, a, w, kind, lat, m, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
